// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants for the loader/cpu memory arbiter
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int M_WASM = 0;
  localparam int M_CPU  = 1;

  localparam logic [1:0] ACC_NONE = 2'b00;
  localparam logic [1:0] ACC_WASM = 2'b01;
  localparam logic [1:0] ACC_CPU  = 2'b10;

endpackage

// File: rtl/mem_arb_timer.sv
// rtl/mem_arb_timer.sv - BUSY-cycle counter flagging the last cycle before abort
module mem_arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  // TIMEOUT of zero means wait for the memory forever
  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign tc = 1'b0;
    end else begin : g_timeout
      assign tc = (count == W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter of the data memory between wasm loader and cpu
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boot_done,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_done,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_done,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  input  logic              mem_ready,
  output logic [1:0]        mem_access
);

  logic [1:0] state;
  logic       last_grant;
  logic       owner;
  logic       we_l;
  logic       elig0;
  logic       elig1;
  logic       grant_cpu;
  logic       do_grant;
  logic       tc;
  logic       in_busy;

  // the cpu is masked until the loader has finished booting
  assign elig0     = m0_req;
  assign elig1     = m1_req & boot_done;
  assign grant_cpu = elig1 & (~elig0 | (last_grant == 1'(M_WASM)));
  assign do_grant  = (state == ST_IDLE) & (elig0 | elig1);
  assign in_busy   = (state == ST_BUSY);

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (do_grant),
    .en    (in_busy),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'(M_CPU);
      owner      <= 1'(M_WASM);
      we_l       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_access <= ACC_NONE;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      m0_done    <= 1'b0;
      m1_done    <= 1'b0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      m0_err  <= 1'b0;
      m1_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (do_grant) begin
            owner      <= grant_cpu;
            we_l       <= grant_cpu ? m1_we : m0_we;
            mem_addr   <= grant_cpu ? m1_addr : m0_addr;
            mem_wdata  <= grant_cpu ? m1_wdata : m0_wdata;
            mem_rd_en  <= grant_cpu ? ~m1_we : ~m0_we;
            mem_wr_en  <= grant_cpu ? m1_we : m0_we;
            mem_access <= grant_cpu ? ACC_CPU : ACC_WASM;
            state      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // a ready arriving on the terminal-count cycle still completes cleanly
          if (mem_ready || tc) begin
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            last_grant <= owner;
            state      <= ST_GAP;
            if (owner == 1'(M_CPU)) begin
              m1_done <= 1'b1;
              m1_err  <= ~mem_ready;
              if (mem_ready && !we_l) m1_rdata <= mem_rdata;
            end else begin
              m0_done <= 1'b1;
              m0_err  <= ~mem_ready;
              if (mem_ready && !we_l) m0_rdata <= mem_rdata;
            end
          end
        end
        ST_GAP: begin
          mem_access <= ACC_NONE;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        boot_done;
  logic        m0_req, m0_we;
  logic [31:0] m0_addr;
  logic [7:0]  m0_wdata, m0_rdata;
  logic        m0_done, m0_err;
  logic        m1_req, m1_we;
  logic [31:0] m1_addr;
  logic [7:0]  m1_wdata, m1_rdata;
  logic        m1_done, m1_err;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_rd_en, mem_wr_en, mem_ready;
  logic [1:0]  mem_access;

  int errors = 0;
  int checks = 0;
  int both_cnt = 0;
  int m0_cnt, m1_cnt, acc10_cnt;
  logic [1:0] exp_acc [3];

  mem_arbiter #(.ADDR_W(32), .DATA_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .boot_done(boot_done),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_ready(mem_ready),
    .mem_access(mem_access)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (mem_rd_en && mem_wr_en) both_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; boot_done = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
    #2;
    chk("rst_access", 32'(mem_access), 32'h0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_done", 32'(m0_done), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // m0 read of 0x10, ready on the third BUSY cycle
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    tick();
    chk("t1_access", 32'(mem_access), 32'h1);
    chk("t1_addr", mem_addr, 32'h10);
    chk("t1_wr_en", 32'(mem_wr_en), 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("t1_rd_en", 32'(mem_rd_en), 32'h1);
      chk("t1_no_early_done", 32'(m0_done), 32'h0);
      if (i == 2) begin mem_ready = 1; mem_rdata = 8'hA5; end
      tick();
    end
    mem_ready = 0; m0_req = 0;
    chk("t1_done", 32'(m0_done), 32'h1);
    chk("t1_err", 32'(m0_err), 32'h0);
    chk("t1_rdata", 32'(m0_rdata), 32'hA5);
    chk("t1_gap_rd_en", 32'(mem_rd_en), 32'h0);
    chk("t1_gap_access", 32'(mem_access), 32'h1);
    tick();
    chk("t1_idle_access", 32'(mem_access), 32'h0);
    chk("t1_done_once", 32'(m0_done), 32'h0);

    // boot phase: only m0 may be granted, zero-wait memory
    m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0; mem_ready = 1; mem_rdata = 8'h77;
    m0_cnt = 0; m1_cnt = 0; acc10_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (m0_done) m0_cnt++;
      if (m1_done) m1_cnt++;
      if (mem_access == 2'b10) acc10_cnt++;
    end
    chk("t2_m0_dones", 32'(m0_cnt), 32'd4);
    chk("t2_m1_dones", 32'(m1_cnt), 32'd0);
    chk("t2_acc_cpu", 32'(acc10_cnt), 32'd0);
    boot_done = 1;
    exp_acc[0] = 2'b10; exp_acc[1] = 2'b01; exp_acc[2] = 2'b10;
    for (int g = 0; g < 3; g++) begin
      tick();
      chk("t2_rr_access", 32'(mem_access), 32'(exp_acc[g]));
      tick();
      chk("t2_rr_done", 32'(exp_acc[g] == 2'b10 ? m1_done : m0_done), 32'h1);
      tick();
    end
    m0_req = 0; m1_req = 0; mem_ready = 0;
    tick();

    // m1 zero-wait write of 0x3C to 0x4; wdata change after grant is ignored
    m1_req = 1; m1_we = 1; m1_addr = 32'h4; m1_wdata = 8'h3C; mem_ready = 1;
    tick();
    m1_wdata = 8'hFF;
    chk("t3_wr_en", 32'(mem_wr_en), 32'h1);
    chk("t3_rd_en", 32'(mem_rd_en), 32'h0);
    chk("t3_wdata", 32'(mem_wdata), 32'h3C);
    chk("t3_addr", mem_addr, 32'h4);
    tick();
    m1_req = 0; mem_ready = 0;
    chk("t3_done", 32'(m1_done), 32'h1);
    chk("t3_err", 32'(m1_err), 32'h0);
    chk("t3_gap_wr_en", 32'(mem_wr_en), 32'h0);
    chk("t3_gap_access", 32'(mem_access), 32'h2);
    chk("t3_rdata_kept", 32'(m1_rdata), 32'h77);
    tick();
    chk("t3_idle_access", 32'(mem_access), 32'h0);

    // timeout: memory never ready, m1 waiting behind
    m0_req = 1; m0_we = 0; m0_addr = 32'h20; m1_req = 1; m1_we = 0; mem_rdata = 8'h99;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_rd_en", 32'(mem_rd_en), 32'h1);
      chk("t4_access", 32'(mem_access), 32'h1);
    end
    tick();
    m0_req = 0;
    chk("t4_done", 32'(m0_done), 32'h1);
    chk("t4_err", 32'(m0_err), 32'h1);
    chk("t4_rdata_kept", 32'(m0_rdata), 32'h77);
    chk("t4_gap_rd_en", 32'(mem_rd_en), 32'h0);
    tick();
    tick();
    chk("t4_m1_next", 32'(mem_access), 32'h2);
    mem_ready = 1; mem_rdata = 8'h42;
    tick();
    m1_req = 0; mem_ready = 0;
    chk("t4_m1_done", 32'(m1_done), 32'h1);
    chk("t4_m1_err", 32'(m1_err), 32'h0);
    chk("t4_m1_rdata", 32'(m1_rdata), 32'h42);
    tick();

    // reset in the second BUSY cycle aborts without a done pulse
    m0_req = 1; m0_we = 0; m0_addr = 32'h30;
    tick();
    tick();
    rst_n = 0;
    #1;
    chk("t5_rst_rd_en", 32'(mem_rd_en), 32'h0);
    chk("t5_rst_access", 32'(mem_access), 32'h0);
    chk("t5_rst_addr", mem_addr, 32'h0);
    chk("t5_rst_rdata", 32'(m0_rdata), 32'h0);
    m0_req = 0; m1_req = 1;
    tick();
    chk("t5_no_done", 32'(m0_done), 32'h0);
    rst_n = 1;
    tick();
    chk("t5_m1_first", 32'(mem_access), 32'h2);
    mem_ready = 1;
    tick();
    chk("t5_m1_done", 32'(m1_done), 32'h1);
    m1_req = 0; mem_ready = 0;
    tick();
    rst_n = 0;
    tick();
    rst_n = 1; m0_req = 1; m1_req = 1;
    tick();
    chk("t5_tie_m0", 32'(mem_access), 32'h1);
    mem_ready = 1;
    tick();
    m0_req = 0; m1_req = 0; mem_ready = 0;
    tick();

    // ready on the terminal-count cycle wins over timeout
    m0_req = 1; m0_we = 0; m0_addr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_rd_en", 32'(mem_rd_en), 32'h1);
      if (i == 3) begin mem_ready = 1; mem_rdata = 8'hC3; end
    end
    tick();
    m0_req = 0; mem_ready = 0;
    chk("t6_done", 32'(m0_done), 32'h1);
    chk("t6_err", 32'(m0_err), 32'h0);
    chk("t6_rdata", 32'(m0_rdata), 32'hC3);
    tick();
    chk("t6_idle_access", 32'(mem_access), 32'h0);

    chk("rd_wr_exclusive", 32'(both_cnt), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates the single byte-wide data memory between two masters: m0 is the wasm loader and m1 is the cpu. Each access runs as a single-outstanding transaction (req/done handshake). The arbiter drives the memory's addr/data/rd_en/wr_en and sees its ready strobe. It replaces the static rom_mapped-driven select with true arbitration, a boot-phase mask and an access timeout.

Parameters:
ADDR_W, 32, address width of masters and memory
DATA_W, 8, data width
TIMEOUT, 255, max BUSY cycles waiting for mem_ready before abort; 0 disables timeout

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
boot_done  in  1  0: only m0 may be granted; 1: round-robin m0/m1
m0_req  in  1  m0 access request, held until m0_done
m0_we  in  1  1 write, 0 read
m0_addr  in  ADDR_W  m0 address
m0_wdata  in  DATA_W  m0 write data
m0_rdata  out  DATA_W  m0 read data, valid with m0_done
m0_done  out  1  one-cycle completion pulse
m0_err  out  1  one-cycle pulse with m0_done on timeout
m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_done, m1_err  same as m0 for cpu
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_rd_en  out  1  read enable
mem_wr_en  out  1  write enable
mem_ready  in  1  memory completion strobe
mem_access  out  2  one-hot owner: 2'b01 m0, 2'b10 m1, 2'b00 none

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0. last_grant=1, so m0 wins the first tie. Timer 0. Reset mid-transaction aborts it with no done pulse.
- States: IDLE, BUSY, GAP.
- IDLE: eligible = {m1_req & boot_done, m0_req}.
  - None eligible: stay.
  - One eligible: grant it.
  - Both eligible: grant the one != last_grant.
  - On grant: latch addr/we/wdata into mem_addr/mem_wdata, set mem_access one-hot, clear timer, go BUSY.
- BUSY: mem_rd_en = ~we_latched and mem_wr_en = we_latched, both registered and held high for the whole state. Timer increments each cycle.
  - mem_ready=1: for a read, capture mem_rdata into the granted mK_rdata. Pulse mK_done next cycle. last_grant := granted. Go GAP.
  - TIMEOUT!=0 and timer==TIMEOUT-1 with no ready: pulse mK_done and mK_err together, mK_rdata unchanged, last_grant := granted, go GAP.
  - mem_ready and timeout in the same cycle: ready wins, no err.
- GAP: enables low for exactly one cycle. mem_access keeps the owner; done/err pulse is high in this cycle. Next cycle IDLE with mem_access=2'b00.
- Latency:
  - req sampled in IDLE at cycle 0 gives enables high at cycle 1.
  - mem_ready sampled at cycle k gives done at cycle k+1.
  - Minimum request-to-done is 2 cycles; minimum back-to-back period is 3 cycles.
- mK_rdata holds its value until that master's next read completes.
- req dropping mid-transaction is ignored; the access completes and done still pulses.
- Changes to addr/we/wdata after grant have no effect (latched).
- boot_done falling while m1 is in BUSY: the m1 access completes normally; masking applies only at the next IDLE decision.
- mem_ready outside BUSY is ignored.
- mem_rd_en and mem_wr_en are never high simultaneously.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, BUSY, GAP)
  - master index constants M_WASM=0, M_CPU=1
  - mem_access encodings ACC_NONE=2'b00, ACC_WASM=2'b01, ACC_CPU=2'b10
- Sub-module mem_arb_timer: clear/enable counter with a terminal-count flag, width $clog2(TIMEOUT+1), disabled when TIMEOUT=0.

Test Plan:
- Reset, then m0 read of 0x00000010 with the memory model returning 0xA5 after 3 cycles → mem_rd_en high for 3 cycles, mem_access=01, m0_done pulses once, m0_rdata=0xA5, m0_err=0.
- boot_done=0, m0 and m1 both request continuously → only m0 granted, mem_access never 10, m1_done never asserts. Then boot_done=1 → grants alternate m1, m0, m1 (last_grant was m0).
- m1 write 0x3C to 0x00000004 with zero-wait ready → mem_wr_en high 1 cycle, mem_wdata=0x3C, m1_done 2 cycles after req, then 1 GAP cycle with enables low.
- TIMEOUT=4, memory never readies → enables high exactly 4 cycles, m0_done and m0_err pulse together, m0_rdata unchanged, arbiter returns to IDLE and serves m1 next.
- rst_n asserted in the 2nd BUSY cycle → all outputs 0 immediately, no done pulse. After release, a pending m1 request is granted first only if m0 is idle.
- mem_ready on the same cycle as terminal count (TIMEOUT=4, ready in cycle 4) → done pulses, err=0, rdata captured.
